// File: rtl/bypass_regfile.sv
// Register file with a DEPTH-stage in-flight delay line and youngest-first
// forwarding onto two combinational read ports.
module bypass_regfile #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned ADDR     = 4,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [ADDR-1:0]  wr_index,
    input  logic [WIDTH-1:0] wr_value,
    input  logic [ADDR-1:0]  rd0_index,
    input  logic [ADDR-1:0]  rd1_index,
    output logic [WIDTH-1:0] rd0_value,
    output logic [WIDTH-1:0] rd1_value,
    output logic             rd0_hit,
    output logic             rd1_hit,
    output logic             commit_valid,
    output logic             busy
);

    localparam int unsigned NREG  = 2 ** ADDR;
    localparam int unsigned NPORT = 2;

    logic             sValid [DEPTH];
    logic [ADDR-1:0]  sIndex [DEPTH];
    logic [WIDTH-1:0] sValue [DEPTH];
    logic [WIDTH-1:0] rf     [NREG];

    logic             wrValidEff;
    logic [ADDR-1:0]  rdIndex [NPORT];
    logic [WIDTH-1:0] rdValue [NPORT];
    logic             rdHit   [NPORT];

    // Writes to the hardwired zero register are dropped before they can forward.
    assign wrValidEff = wr_valid && !((ZERO_REG != 0) && (wr_index == '0));

    // In-flight delay line; advances every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                sValid[k] <= 1'b0;
                sIndex[k] <= '0;
                sValue[k] <= '0;
            end
        end else begin
            sValid[0] <= wrValidEff;
            sIndex[0] <= wr_index;
            sValue[0] <= wr_value;
            for (int k = 1; k < int'(DEPTH); k++) begin
                sValid[k] <= sValid[k-1];
                sIndex[k] <= sIndex[k-1];
                sValue[k] <= sValue[k-1];
            end
        end
    end

    // Commit from the last stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < int'(NREG); r++) begin
                rf[r] <= '0;
            end
        end else if (sValid[DEPTH-1]) begin
            rf[sIndex[DEPTH-1]] <= sValue[DEPTH-1];
        end
    end

    assign rdIndex[0] = rd0_index;
    assign rdIndex[1] = rd1_index;

    // Oldest source is applied first so younger matches overwrite it.
    always_comb begin
        for (int p = 0; p < int'(NPORT); p++) begin
            rdValue[p] = rf[rdIndex[p]];
            rdHit[p]   = 1'b0;
            for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
                if (sValid[k] && (sIndex[k] == rdIndex[p])) begin
                    rdValue[p] = sValue[k];
                    rdHit[p]   = 1'b1;
                end
            end
            if (wrValidEff && (wr_index == rdIndex[p])) begin
                rdValue[p] = wr_value;
                rdHit[p]   = 1'b1;
            end
            if (rst || ((ZERO_REG != 0) && (rdIndex[p] == '0))) begin
                rdValue[p] = '0;
                rdHit[p]   = 1'b0;
            end
        end
    end

    assign rd0_value = rdValue[0];
    assign rd1_value = rdValue[1];
    assign rd0_hit   = rdHit[0];
    assign rd1_hit   = rdHit[1];

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            busy = busy | sValid[k];
        end
        busy = busy & !rst;
    end

    assign commit_valid = sValid[DEPTH-1] & !rst;

endmodule

// File: doc/bypass_regfile.md
# bypass_regfile

Parametrised register file with a built-in multi-stage forwarding network for the in-order pipeline. Results enter a DEPTH-stage in-flight delay line. They commit to the register file DEPTH cycles later. Two read ports resolve the youngest matching value combinationally, from the incoming result, the in-flight stages, or the register file. It generalises the single-stage 16×16 bypass to configurable width, register count and writeback distance, and adds a hardwired-zero register option.

## Interface
- WIDTH, 16, data width in bits
- ADDR, 4, index width; register count NREG = 2**ADDR
- DEPTH, 3, in-flight stages between result capture and commit; legal range 1..8
- ZERO_REG, 0, when 1, register 0 always reads 0 and writes to it are discarded
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  asynchronous reset, active-high
- wr_valid  in  1  a result is presented this cycle
- wr_index  in  ADDR  destination register of the result
- wr_value  in  WIDTH  result data
- rd0_index, rd1_index  in  ADDR  read port source indices
- rd0_value, rd1_value  out  WIDTH  resolved operand, combinational
- rd0_hit, rd1_hit  out  1  operand came from wr input or an in-flight stage, not the register file
- commit_valid  out  1  stage DEPTH-1 holds a valid entry that commits at the next edge
- busy  out  1  OR of all in-flight stage valid bits

## Operation
- State:
  - In-flight stages s[0..DEPTH-1], each holding {valid, index, value}.
  - Register array rf[0..NREG-1].
- Each posedge, when rst is low:
  - s[0] ← {wr_valid_eff, wr_index, wr_value}.
  - s[k] ← s[k-1] for k ≥ 1.
  - If s[DEPTH-1].valid, rf[s[DEPTH-1].index] ← s[DEPTH-1].value.
- wr_valid_eff = wr_valid & !(ZERO_REG & wr_index == 0). A discarded write never becomes valid and never forwards.
- Read resolution, per port, independently. Priority is youngest first:
  1. wr input, if wr_valid_eff and wr_index == rd_index.
  2. s[0] through s[DEPTH-1], first valid stage whose index matches.
  3. rf[rd_index].
- hit = 1 for sources 1 and 2, and 0 for source 3.
- ZERO_REG = 1 and rd_index == 0: value 0, hit 0, regardless of anything else.
- Multiple in-flight entries to the same index are legal. The youngest wins on reads, and commits land in program order, so the last one written persists.
- Both ports may read the same index. Both return the identical value and hit.
- No stall input: the delay line advances every cycle.

## Timing
- Result presented with wr_valid in cycle t:
  - visible on read ports in cycle t via bypass (zero-cycle forward);
  - sits in s[k] during cycle t+1+k;
  - written into rf at the edge ending cycle t+DEPTH;
  - served by rf (hit = 0) from cycle t+DEPTH+1.
- commit_valid in cycle c equals s[DEPTH-1].valid in cycle c.
- Reset (asynchronous, takes effect immediately):
  - All stage valids clear to 0, all rf entries clear to 0.
  - While rst is high, rd*_value = 0, rd*_hit = 0, commit_valid = 0, busy = 0; wr input is not forwarded.
- Reset asserted mid-operation drops all in-flight results, uncommitted ones included. After release, the first capture happens at the first posedge with rst low.
- Outputs depend combinationally on rd*_index, wr_*, and state. There is no path from outputs back to inputs.

## Test plan
- Reset, then read all indices on both ports (WIDTH=16, ADDR=4, DEPTH=3) → every value 0x0000, hit 0, busy 0.
- Write idx 5 = 0xBEEF in cycle 0 and read idx 5 every cycle:
  - cycles 0–3 return 0xBEEF with hit 1;
  - cycle 4 returns 0xBEEF with hit 0;
  - commit_valid is high in cycle 3 only.
- Back-to-back writes to idx 7, 0x1111 in cycle 0 then 0x2222 in cycle 1:
  - read in cycle 1 → 0x2222;
  - read in cycle 5 → 0x2222, hit 0 (rf holds the later value).
- ZERO_REG=1, write idx 0 = 0xFFFF → rd0 on idx 0 returns 0, hit 0 in all cycles; busy stays 0.
- Write idx 3 = 0xAAAA, then assert rst in cycle 2 (before commit) and release → idx 3 reads 0x0000, hit 0.
- rd0 = rd1 = idx 9 while wr to idx 9 = 0x0042 and s[1] holds idx 9 = 0x0041 → both ports return 0x0042, hit 1.
